// File: rtl/vram_hdma.sv
// vram_hdma: MMIO-programmed block copier into VRAM. Runs either one stalled
// general-purpose burst or one block per PPU HBlank, owning the buses while a block runs.
module vram_hdma #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF51,
  parameter int          BLOCK_BYTES = 16,
  parameter int          LEN_BITS    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ct,
  input  logic [15:0] mmio_a,
  input  logic [7:0]  mmio_din,
  output logic [7:0]  mmio_dout,
  input  logic        mmio_rd,
  input  logic        mmio_wr,
  input  logic        hblank_start,
  input  logic        lcd_on,
  output logic [15:0] dma_a,
  input  logic [7:0]  dma_din,
  output logic [7:0]  dma_dout,
  output logic        dma_rd,
  output logic        dma_wr,
  output logic        dma_occupy_extbus,
  output logic        dma_occupy_vidbus,
  output logic        cpu_stall,
  output logic        busy
);
  localparam int         AW      = $clog2(BLOCK_BYTES);
  localparam logic [7:0] LO_MASK = 8'(~((1 << AW) - 1));

  typedef enum logic [1:0] {IDLE, ARMED_HB, BLOCK, STOP} state_t;

  state_t              state, state_nx;
  logic [15:0]         src;
  logic [12:0]         dst;
  logic [LEN_BITS-1:0] remaining;
  logic [AW-1:0]       byte_cnt;
  logic [7:0]          data_q;
  logic                hb_mode;
  logic                cancel_q;

  logic [15:0] reg_off;
  logic        reg_hit, wr_en, ctrl_wr, cancel_wr, hb_cancel_now, blk_last;
  logic [2:0]  reg_idx;
  state_t      start_st;

  assign reg_off = mmio_a - BASE_ADDR;
  assign reg_hit = reg_off < 16'd5;
  assign reg_idx = reg_off[2:0];
  assign wr_en   = mmio_wr && reg_hit;
  assign ctrl_wr = wr_en && (reg_idx == 3'd4);
  assign cancel_wr     = ctrl_wr && !mmio_din[7];
  assign hb_cancel_now = cancel_wr && hb_mode && (state == BLOCK);
  assign blk_last      = (state == BLOCK) && (ct == 2'd3) && (&byte_cnt);

  // STOP parks a triggered transfer until the next M-cycle boundary, so a
  // block always begins on ct=0; a trigger seen on ct=3 skips the wait.
  assign start_st = (ct == 2'd3) ? BLOCK : STOP;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (ctrl_wr) begin
          if (!mmio_din[7] || !lcd_on) state_nx = start_st;
          else                         state_nx = ARMED_HB;
        end
      ARMED_HB:
        if (cancel_wr)                      state_nx = IDLE;
        else if (hblank_start && lcd_on)    state_nx = start_st;
      STOP:
        if (hb_mode && cancel_wr)           state_nx = IDLE;
        else if (ct == 2'd3)                state_nx = BLOCK;
      BLOCK:
        if (blk_last) begin
          if (remaining == '0 || cancel_q || hb_cancel_now) state_nx = IDLE;
          else if (hb_mode)                                 state_nx = ARMED_HB;
          else                                              state_nx = BLOCK;
        end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '1;
      byte_cnt  <= '0;
      data_q    <= '0;
      hb_mode   <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      // Address/length registers only take writes while fully idle.
      if (state == IDLE && wr_en)
        case (reg_idx)
          3'd0: src[15:8] <= mmio_din;
          3'd1: src[7:0]  <= mmio_din & LO_MASK;
          3'd2: dst[12:8] <= mmio_din[4:0];
          3'd3: dst[7:0]  <= mmio_din & LO_MASK;
          3'd4: begin
            remaining <= mmio_din[LEN_BITS-1:0];
            hb_mode   <= mmio_din[7];
            cancel_q  <= 1'b0;
          end
          default: ;
        endcase
      if (hb_cancel_now) cancel_q <= 1'b1;
      if (state == BLOCK) begin
        if (ct == 2'd1) data_q <= dma_din;
        if (ct == 2'd3) begin
          src      <= src + 16'd1;
          dst      <= dst + 13'd1;
          byte_cnt <= byte_cnt + 1'b1;
          if (&byte_cnt) remaining <= remaining - 1'b1;
        end
      end
    end

  // Bus strobes follow ct directly: read slot on ct 0-1, write slot on ct 2.
  always_comb begin
    dma_a    = '0;
    dma_rd   = 1'b0;
    dma_wr   = 1'b0;
    dma_dout = data_q;
    if (state == BLOCK) begin
      if (ct == 2'd0 || ct == 2'd1) begin
        dma_a  = src;
        dma_rd = 1'b1;
      end else if (ct == 2'd2) begin
        dma_a  = {3'b100, dst};
        dma_wr = 1'b1;
      end
    end
    dma_occupy_extbus = (state == BLOCK);
    dma_occupy_vidbus = (state == BLOCK);
    cpu_stall         = (state == BLOCK);
    busy              = (state != IDLE);
  end

  logic [6:0] ctrl_low;
  always_comb begin
    ctrl_low                 = '1;
    ctrl_low[LEN_BITS-1:0]   = remaining;
    mmio_dout                = 8'hFF;
    if (mmio_rd && reg_hit && reg_idx == 3'd4)
      mmio_dout = {state == IDLE, ctrl_low};
  end

endmodule

// File: tb/tb_vram_hdma.sv
// Directed bench for vram_hdma: a memory model feeds reads, and every expected
// VRAM write is queued at programming time and checked when dma_wr fires.
module tb_vram_hdma;
  localparam logic [15:0] BASE = 16'hFF51;
  localparam int          BB   = 16;

  logic        clk, rst;
  logic [1:0]  ct;
  logic [15:0] mmio_a;
  logic [7:0]  mmio_din, mmio_dout;
  logic        mmio_rd, mmio_wr, hblank_start, lcd_on;
  logic [15:0] dma_a;
  logic [7:0]  dma_din, dma_dout;
  logic        dma_rd, dma_wr, occ_ext, occ_vid, cpu_stall, busy;

  vram_hdma dut (
    .clk(clk), .rst(rst), .ct(ct),
    .mmio_a(mmio_a), .mmio_din(mmio_din), .mmio_dout(mmio_dout),
    .mmio_rd(mmio_rd), .mmio_wr(mmio_wr),
    .hblank_start(hblank_start), .lcd_on(lcd_on),
    .dma_a(dma_a), .dma_din(dma_din), .dma_dout(dma_dout),
    .dma_rd(dma_rd), .dma_wr(dma_wr),
    .dma_occupy_extbus(occ_ext), .dma_occupy_vidbus(occ_vid),
    .cpu_stall(cpu_stall), .busy(busy)
  );

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int rd_seen, wr_seen, occ_seen;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign dma_din = mem_byte(dma_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    ct = 2'd0;
    forever begin
      @(posedge clk);
      #1 ct = ct + 2'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk)
    if (dma_wr === 1'b1) begin
      chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(dma_a), 32'(e.a));
        chk("wr_data", 32'(dma_dout), 32'(e.d));
      end
    end

  task automatic expect_copy(input logic [15:0] src, input logic [15:0] dst_off, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      logic [15:0] s;
      s   = (src & 16'(~(BB - 1))) + 16'(i);
      e.a = 16'h8000 | (((dst_off & 16'h1FFF & 16'(~(BB - 1))) + 16'(i)) & 16'h1FFF);
      e.d = mem_byte(s);
      exp_q.push_back(e);
    end
  endtask

  task automatic wr_reg(input logic [2:0] idx, input logic [7:0] v);
    @(posedge clk); #1;
    mmio_a = BASE + 16'(idx); mmio_din = v; mmio_wr = 1'b1;
    @(posedge clk); #1;
    mmio_wr = 1'b0;
  endtask

  task automatic program_regs(input logic [15:0] src, input logic [7:0] dhi, input logic [7:0] dlo);
    wr_reg(3'd0, src[15:8]);
    wr_reg(3'd1, src[7:0]);
    wr_reg(3'd2, dhi);
    wr_reg(3'd3, dlo);
  endtask

  task automatic rd_ctrl(output logic [7:0] v);
    @(posedge clk); #1;
    mmio_a = BASE + 16'd4; mmio_rd = 1'b1;
    #2 v = mmio_dout;
    mmio_rd = 1'b0;
  endtask

  task automatic hb_pulse();
    @(posedge clk); #1 hblank_start = 1'b1;
    @(posedge clk); #1 hblank_start = 1'b0;
  endtask

  task automatic run(input int n);
    rd_seen = 0; wr_seen = 0; occ_seen = 0;
    repeat (n) begin
      @(negedge clk);
      rd_seen  += int'(dma_rd);
      wr_seen  += int'(dma_wr);
      occ_seen += int'(occ_ext | occ_vid | cpu_stall);
    end
  endtask

  task automatic wait_idle(input int budget, output int stall);
    stall = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cpu_stall) stall++;
      if (!busy) break;
    end
  endtask

  task automatic check_quiet(input string t);
    chk({t, "_mmio_dout"}, 32'(mmio_dout), 32'hFF);
    chk({t, "_dma_a"},     32'(dma_a),     32'h0);
    chk({t, "_dma_rd"},    32'(dma_rd),    32'h0);
    chk({t, "_dma_wr"},    32'(dma_wr),    32'h0);
    chk({t, "_occ_ext"},   32'(occ_ext),   32'h0);
    chk({t, "_occ_vid"},   32'(occ_vid),   32'h0);
    chk({t, "_stall"},     32'(cpu_stall), 32'h0);
    chk({t, "_busy"},      32'(busy),      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int stall;
    rst = 1'b1; mmio_a = '0; mmio_din = '0; mmio_rd = 1'b0; mmio_wr = 1'b0;
    hblank_start = 1'b0; lcd_on = 1'b1;

    // Reset state
    #2;
    check_quiet("rst");
    chk("rst_dma_dout", 32'(dma_dout), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rd_ctrl(v);
    chk("rst_ctrl", 32'(v), 32'hFF);

    // GP transfer: 2 blocks C000 -> 8800, stall exactly 128 clks
    program_regs(16'hC000, 8'h08, 8'h00);
    expect_copy(16'hC000, 16'h0800, 32);
    wr_reg(3'd4, 8'h01);
    wait_idle(400, stall);
    chk("gp_idle", 32'(busy), 32'd0);
    chk("gp_stall_clks", 32'(stall), 32'd128);
    chk("gp_queue", 32'(exp_q.size()), 32'd0);
    rd_ctrl(v);
    chk("gp_ctrl", 32'(v), 32'hFF);

    // HB transfer: 3 blocks, one per HBlank
    lcd_on = 1'b1;
    program_regs(16'hD000, 8'h00, 8'h00);
    wr_reg(3'd4, 8'h82);
    rd_ctrl(v);
    chk("hb_ctrl_armed", 32'(v), 32'h02);
    run(40);
    chk("hb_armed_busy", 32'(busy), 32'd1);
    chk("hb_armed_rd", 32'(rd_seen), 32'd0);
    chk("hb_armed_occ", 32'(occ_seen), 32'd0);
    for (int k = 0; k < 3; k++) begin
      expect_copy(16'hD000 + 16'(k * BB), 16'(k * BB), BB);
      hb_pulse();
      run(90);
      chk("hb_block_writes", 32'(wr_seen), 32'(BB));
      chk("hb_queue", 32'(exp_q.size()), 32'd0);
      rd_ctrl(v);
      chk("hb_ctrl_after", 32'(v), (k == 2) ? 32'hFF : 32'(8'h01 - 8'(k)));
      if (k < 2) begin
        run(30);
        chk("hb_gap_rd", 32'(rd_seen), 32'd0);
        chk("hb_gap_occ", 32'(occ_seen), 32'd0);
      end
    end
    chk("hb_done_busy", 32'(busy), 32'd0);

    // HB cancel mid-block: current block completes, then idle with remaining 2
    program_regs(16'hC100, 8'h10, 8'h00);
    wr_reg(3'd4, 8'h83);
    expect_copy(16'hC100, 16'h1000, BB);
    hb_pulse();
    run(20);
    chk("cancel_inflight", 32'(cpu_stall), 32'd1);
    wr_reg(3'd4, 8'h00);
    run(80);
    chk("cancel_queue", 32'(exp_q.size()), 32'd0);
    chk("cancel_busy", 32'(busy), 32'd0);
    rd_ctrl(v);
    chk("cancel_ctrl", 32'(v), 32'h82);
    hb_pulse();
    run(80);
    chk("cancel_late_rd", 32'(rd_seen), 32'd0);
    chk("cancel_late_busy", 32'(busy), 32'd0);

    // Wrap and alignment: source FFF0 -> 0000, destination 9FF0 -> 8000
    program_regs(16'hFFF7, 8'h1F, 8'hF0);
    expect_copy(16'hFFF7, 16'h1FF0, 32);
    wr_reg(3'd4, 8'h01);
    wait_idle(400, stall);
    chk("wrap_stall", 32'(stall), 32'd128);
    chk("wrap_queue", 32'(exp_q.size()), 32'd0);
    rd_ctrl(v);
    chk("wrap_ctrl", 32'(v), 32'hFF);

    // LCD off: HB request runs straight away
    lcd_on = 1'b0;
    program_regs(16'hC200, 8'h02, 8'h00);
    expect_copy(16'hC200, 16'h0200, BB);
    wr_reg(3'd4, 8'h80);
    wait_idle(200, stall);
    chk("lcdoff_stall", 32'(stall), 32'd64);
    chk("lcdoff_queue", 32'(exp_q.size()), 32'd0);
    rd_ctrl(v);
    chk("lcdoff_ctrl", 32'(v), 32'hFF);
    lcd_on = 1'b1;

    // Reset in the middle of byte 5 of a GP block
    program_regs(16'hC300, 8'h03, 8'h00);
    expect_copy(16'hC300, 16'h0300, 5);
    wr_reg(3'd4, 8'h00);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    chk("midrst_prewrites", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_quiet("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(100);
    chk("midrst_no_wr", 32'(wr_seen), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rd_ctrl(v);
    chk("midrst_ctrl", 32'(v), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
